// File: rtl/key_loader.sv
// rtl/key_loader.sv - assembles a KEY_W key from WORD_W words MSW-first and holds it until acknowledged
module key_loader #(
   parameter int WORD_W = 32,
   parameter int KEY_W  = 128
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [WORD_W-1:0]                    in_data,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic                                 clear,
   output logic [KEY_W-1:0]                     key_out,
   output logic                                 key_valid,
   output logic                                 start,
   input  logic                                 key_ack,
   output logic [$clog2(KEY_W/WORD_W):0]        word_cnt
);

   localparam int NWORDS = KEY_W / WORD_W;
   localparam int CNT_W  = $clog2(NWORDS) + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t           state_q;
   state_t           state_d;
   logic [KEY_W-1:0] shreg;
   logic             accept;
   logic             last_word;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = (state_q == FILL) && !clear;
      accept    = in_valid && in_ready;
      last_word = accept && (word_cnt == LAST_CNT);
      if (clear) begin
         state_d = FILL;
      end else begin
         case (state_q)
            FILL: if (last_word) state_d = HOLD;
            HOLD: if (key_ack)   state_d = FILL;
            default:             state_d = FILL;
         endcase
      end
   end

   // key_ack is only honoured in HOLD and accept only happens in FILL, so they never collide
   always_ff @(posedge clk) begin
      if (!rst) begin
         shreg     <= '0;
         key_out   <= '0;
         key_valid <= 1'b0;
         start     <= 1'b0;
         word_cnt  <= '0;
      end else if (clear) begin
         shreg     <= '0;
         key_out   <= '0;
         key_valid <= 1'b0;
         start     <= 1'b0;
         word_cnt  <= '0;
      end else begin
         start <= 1'b0;
         if (state_q == HOLD && key_ack) begin
            key_valid <= 1'b0;
         end else if (accept) begin
            shreg <= {shreg[KEY_W-WORD_W-1:0], in_data};
            if (last_word) begin
               key_out   <= {shreg[KEY_W-WORD_W-1:0], in_data};
               key_valid <= 1'b1;
               start     <= 1'b1;
               word_cnt  <= '0;
            end else begin
               word_cnt  <= word_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_key_loader.sv
// tb/tb_key_loader.sv - directed bench for key_loader
module tb_key_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  in_data;
   logic         in_valid;
   logic         in_ready;
   logic         clear;
   logic [127:0] key_out;
   logic         key_valid;
   logic         start;
   logic         key_ack;
   logic [2:0]   word_cnt;

   int vecs = 0;
   int errs = 0;

   key_loader #(.WORD_W(32), .KEY_W(128)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .clear(clear), .key_out(key_out), .key_valid(key_valid), .start(start),
      .key_ack(key_ack), .word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [127:0] k);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = k[127-32*i -: 32];
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; clear = 1'b0; key_ack = 1'b0; in_valid = 1'b1; in_data = 32'hFFFFFFFF;
      tick(); tick();
      vecs++; if (key_out !== 128'h0) begin errs++; $display("FAIL reset_key_out got %h exp 0", key_out); end
      vecs++; if (key_valid !== 1'b0) begin errs++; $display("FAIL reset_key_valid got %b exp 0", key_valid); end
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL reset_start got %b exp 0", start); end
      vecs++; if (word_cnt !== 3'd0) begin errs++; $display("FAIL reset_word_cnt got %0d exp 0", word_cnt); end
      rst = 1'b1; in_valid = 1'b0;
      tick();
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      vecs++; if (word_cnt !== 3'd0) begin errs++; $display("FAIL reset_idle_cnt got %0d exp 0", word_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_cnt;
      in_valid = 1'b1; in_data = 32'hAAAAAAAA;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_cnt = (i == 3) ? 3'd0 : 3'(i + 1);
         vecs++; if (word_cnt !== exp_cnt) begin errs++; $display("FAIL b2b_cnt%0d got %0d exp %0d", i, word_cnt, exp_cnt); end
      end
      vecs++; if (key_out !== {4{32'hAAAAAAAA}}) begin errs++; $display("FAIL b2b_key_out got %h exp %h", key_out, {4{32'hAAAAAAAA}}); end
      vecs++; if (key_valid !== 1'b1) begin errs++; $display("FAIL b2b_key_valid got %b exp 1", key_valid); end
      vecs++; if (start !== 1'b1) begin errs++; $display("FAIL b2b_start got %b exp 1", start); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b_in_ready got %b exp 0", in_ready); end
      tick();
      vecs++; if (start !== 1'b0) begin errs++; $display("FAIL b2b_start_pulse got %b exp 0", start); end
      vecs++; if (key_valid !== 1'b1) begin errs++; $display("FAIL b2b_valid_held got %b exp 1", key_valid); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready_held got %b exp 0", in_ready); end
      in_valid = 1'b0; key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      vecs++; if (key_valid !== 1'b0) begin errs++; $display("FAIL b2b_ack_valid got %b exp 0", key_valid); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ack_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_gaps();
      logic [31:0] gd [7];
      logic        gv [7];
      logic [2:0]  gc [7];
      gd = '{32'h00112233, 32'h0, 32'h44556677, 32'h8899AABB, 32'h0, 32'h0, 32'hCCDDEEFF};
      gv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      gc = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd0};
      for (int i = 0; i < 7; i++) begin
         in_valid = gv[i]; in_data = gd[i];
         tick();
         vecs++; if (word_cnt !== gc[i]) begin errs++; $display("FAIL gaps_cnt%0d got %0d exp %0d", i, word_cnt, gc[i]); end
      end
      in_valid = 1'b0;
      vecs++; if (key_out !== 128'h00112233_44556677_8899AABB_CCDDEEFF) begin errs++; $display("FAIL gaps_key_out got %h exp 00112233445566778899aabbccddeeff", key_out); end
      vecs++; if (key_valid !== 1'b1 || start !== 1'b1) begin errs++; $display("FAIL gaps_valid_start got %b%b exp 11", key_valid, start); end
      key_ack = 1'b1; tick(); key_ack = 1'b0;
   endtask

   task automatic test_hold_ack();
      load_key(128'h11111111_22222222_33333333_44444444);
      vecs++; if (start !== 1'b1) begin errs++; $display("FAIL hold_start got %b exp 1", start); end
      in_valid = 1'b1; in_data = 32'hDEADBEEF;
      for (int i = 0; i < 10; i++) begin
         tick();
         vecs++;
         if (key_out !== 128'h11111111_22222222_33333333_44444444 || key_valid !== 1'b1 ||
             start !== 1'b0 || in_ready !== 1'b0 || word_cnt !== 3'd0) begin
            errs++;
            $display("FAIL hold_cycle%0d got key %h v%b s%b r%b c%0d exp key 11111111222222223333333344444444 v1 s0 r0 c0",
                     i, key_out, key_valid, start, in_ready, word_cnt);
         end
      end
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0; in_valid = 1'b0;
      vecs++; if (key_valid !== 1'b0) begin errs++; $display("FAIL hold_ack_valid got %b exp 0", key_valid); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL hold_ack_ready got %b exp 1", in_ready); end
      vecs++; if (key_out !== 128'h11111111_22222222_33333333_44444444) begin errs++; $display("FAIL hold_ack_key_kept got %h exp 11111111222222223333333344444444", key_out); end
      vecs++; if (word_cnt !== 3'd0) begin errs++; $display("FAIL hold_ack_cnt got %0d exp 0", word_cnt); end
   endtask

   task automatic test_clear();
      in_valid = 1'b1; in_data = 32'h55555555; tick();
      in_data = 32'h66666666; tick();
      vecs++; if (word_cnt !== 3'd2) begin errs++; $display("FAIL clr_pre_cnt got %0d exp 2", word_cnt); end
      clear = 1'b1; in_data = 32'h77777777;
      #1;
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL clr_in_ready got %b exp 0", in_ready); end
      tick();
      clear = 1'b0; in_valid = 1'b0;
      vecs++; if (word_cnt !== 3'd0) begin errs++; $display("FAIL clr_cnt got %0d exp 0", word_cnt); end
      vecs++; if (key_out !== 128'h0 || key_valid !== 1'b0) begin errs++; $display("FAIL clr_key got %h v%b exp 0 v0", key_out, key_valid); end
      load_key(128'h01234567_89ABCDEF_FEDCBA98_76543210);
      vecs++; if (key_out !== 128'h0123456789ABCDEFFEDCBA9876543210) begin errs++; $display("FAIL clr_reload_key got %h exp 0123456789abcdeffedcba9876543210", key_out); end
      vecs++; if (key_valid !== 1'b1) begin errs++; $display("FAIL clr_reload_valid got %b exp 1", key_valid); end
      key_ack = 1'b1; tick(); key_ack = 1'b0;
   endtask

   task automatic test_ack_with_start();
      load_key(128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0);
      vecs++; if (start !== 1'b1 || key_valid !== 1'b1) begin errs++; $display("FAIL ackst_first got s%b v%b exp s1 v1", start, key_valid); end
      key_ack = 1'b1;
      tick();
      key_ack = 1'b0;
      vecs++; if (key_valid !== 1'b0 || start !== 1'b0) begin errs++; $display("FAIL ackst_after got s%b v%b exp s0 v0", start, key_valid); end
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL ackst_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_reset_in_hold();
      load_key(128'h13579BDF_2468ACE0_FFFF0000_0000FFFF);
      tick();
      vecs++; if (key_valid !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL rsth_pre got v%b r%b exp v1 r0", key_valid, in_ready); end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      vecs++;
      if (key_out !== 128'h0 || key_valid !== 1'b0 || start !== 1'b0 || word_cnt !== 3'd0 || in_ready !== 1'b1) begin
         errs++;
         $display("FAIL rsth_outputs got key %h v%b s%b c%0d r%b exp key 0 v0 s0 c0 r1", key_out, key_valid, start, word_cnt, in_ready);
      end
   endtask

   initial begin
      rst = 1'b0; clear = 1'b0; key_ack = 1'b0; in_valid = 1'b0; in_data = '0;
      test_reset();
      test_back_to_back();
      test_gaps();
      test_hold_ack();
      test_clear();
      test_ack_with_start();
      test_reset_in_hold();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
